// File: rtl/picoctrl_core.sv
// PicoCtrl fetch/execute engine: drives the ROM address, latches the instruction and
// conditionally writes one of four output registers or jumps, at two cycles per instruction.
module picoctrl_core #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic [7:0]        cond_in,
  output logic [7:0]        reg0_out,
  output logic [7:0]        reg1_out,
  output logic [7:0]        reg2_out,
  output logic [7:0]        reg3_out,
  output logic              wr_strobe,
  output logic [1:0]        wr_sel,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;
  typedef enum logic [1:0] {ActNop, ActWrite, ActJump, ActRsvd} act_e;

  state_e                          state_q, state_d;
  logic [ADDR_W-1:0]               pc_q, pc_d;
  logic [15:0]                     ir_q, ir_d;
  logic [3:0][7:0]                 regs_q, regs_d;
  logic                            wr_strobe_q, wr_strobe_d;
  logic [1:0]                      wr_sel_q, wr_sel_d;
  logic [SYNC_STAGES-1:0][7:0]     sync_q;

  logic [7:0] cond_sync;
  logic [2:0] cond_k;
  logic       cond_v;
  act_e       act;
  logic [1:0] sel;
  logic [7:0] imm;
  logic       cond_true;

  assign cond_sync = sync_q[SYNC_STAGES-1];
  assign cond_k    = ir_q[15:13];
  assign cond_v    = ir_q[12];
  assign act       = act_e'(ir_q[11:10]);
  assign sel       = ir_q[9:8];
  assign imm       = ir_q[7:0];
  assign cond_true = (cond_sync[cond_k] == cond_v);

  // Stage 0 samples the asynchronous inputs; EXEC only ever sees the last stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cond_in};
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_sel_d    = wr_sel_q;
    case (state_q)
      StIdle: begin
        if (en) state_d = StFetch;
      end
      StFetch: begin
        // rom_data is only trusted here, so X outside FETCH never reaches ir.
        ir_d    = rom_data;
        state_d = StExec;
      end
      StExec: begin
        pc_d = pc_q + ADDR_W'(1);
        if (cond_true) begin
          case (act)
            ActWrite: begin
              regs_d[sel] = imm;
              wr_strobe_d = 1'b1;
              wr_sel_d    = sel;
            end
            ActJump: pc_d = imm[ADDR_W-1:0];
            default: ;
          endcase
        end
        state_d = en ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ir_q        <= '0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_sel_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_sel_q    <= wr_sel_d;
    end
  end

  assign rom_addr  = pc_q;
  assign reg0_out  = regs_q[0];
  assign reg1_out  = regs_q[1];
  assign reg2_out  = regs_q[2];
  assign reg3_out  = regs_q[3];
  assign wr_strobe = wr_strobe_q;
  assign wr_sel    = wr_sel_q;
  assign busy      = (state_q != StIdle);

endmodule
